// File: rtl/kore_op_dispatch.sv
// Instruction dispatcher: FIFO-buffered decode and one-at-a-time issue to the kore functional FSM.
// Optional WAIT timeout is enabled by defining KORE_DISPATCH_TIMEOUT_EN.
module kore_op_dispatch #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        clr_stat,
  output logic [6:0]  opcode,
  output logic [4:0]  pcdata_rs0,
  output logic [4:0]  pcdata_rs1,
  output logic [4:0]  pcdata_rd,
  output logic [2:0]  pcdata_bc,
  output logic        opflag,
  input  logic        eop,
  output logic        busy,
  output logic [15:0] issue_cnt,
  output logic [7:0]  illegal_cnt,
  output logic        timeout_err
);

  // state   | meaning
  // S_IDLE  | drop illegal heads, or latch a legal head and pop it
  // S_ISSUE | bump issue_cnt; opflag is registered high for the next cycle
  // S_WAIT  | hold fields until a fresh eop rising edge (or timeout)
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam int              AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [24:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop, empty, full;
  logic [24:0]   head;
  logic          head_legal;

  state_t        state_q;
  logic          eop_q, eop_rise;
  logic          opflag_q;
  logic [6:0]    opcode_q;
  logic [4:0]    rs0_q, rs1_q, rd_q;
  logic [2:0]    bc_q;
  logic [15:0]   issue_cnt_q;
  logic [7:0]    illegal_cnt_q;

  // Bits [31:25] carry no operand information and are never stored.
  logic          unused_bits;
  assign unused_bits = ^{in_instr[31:25], TMO_LAST};

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == FULL_CNT);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign head     = mem_q[rd_ptr_q];
  assign eop_rise = eop && !eop_q;

  always_comb begin
    head_legal = 1'b0;
    case (head[6:0])
      7'h01, 7'h02, 7'h04: head_legal = 1'b1;
      default:             head_legal = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_instr[24:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

`ifdef KORE_DISPATCH_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        tmo_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      eop_q         <= 1'b0;
      opflag_q      <= 1'b0;
      opcode_q      <= '0;
      rs0_q         <= '0;
      rs1_q         <= '0;
      rd_q          <= '0;
      bc_q          <= '0;
      issue_cnt_q   <= '0;
      illegal_cnt_q <= '0;
`ifdef KORE_DISPATCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      tmo_err_q     <= 1'b0;
`endif
    end else begin
      eop_q    <= eop;
      opflag_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            if (head_legal) begin
              opcode_q <= head[6:0];
              rd_q     <= head[11:7];
              bc_q     <= head[14:12];
              rs0_q    <= head[19:15];
              rs1_q    <= head[24:20];
              state_q  <= S_ISSUE;
            end else if (illegal_cnt_q != 8'hFF) begin
              illegal_cnt_q <= illegal_cnt_q + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          opflag_q    <= 1'b1;
          issue_cnt_q <= issue_cnt_q + 1'b1;
          state_q     <= S_WAIT;
`ifdef KORE_DISPATCH_TIMEOUT_EN
          tmo_cnt_q   <= '0;
`endif
        end
        S_WAIT: begin
          if (eop_rise) begin
            state_q <= S_IDLE;
`ifdef KORE_DISPATCH_TIMEOUT_EN
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q   <= S_IDLE;
            tmo_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Clear wins over any increment or flag set in the same cycle.
      if (clr_stat) begin
        issue_cnt_q   <= '0;
        illegal_cnt_q <= '0;
`ifdef KORE_DISPATCH_TIMEOUT_EN
        tmo_err_q     <= 1'b0;
`endif
      end
    end
  end

`ifdef KORE_DISPATCH_TIMEOUT_EN
  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign opcode      = opcode_q;
  assign pcdata_rs0  = rs0_q;
  assign pcdata_rs1  = rs1_q;
  assign pcdata_rd   = rd_q;
  assign pcdata_bc   = bc_q;
  assign opflag      = opflag_q;
  assign busy        = (state_q != S_IDLE) || !empty;
  assign issue_cnt   = issue_cnt_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_kore_op_dispatch.sv
// Scoreboard bench for kore_op_dispatch: legal words queue expected fields, opflag pops them.
module tb_kore_op_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        clr_stat;
  logic [6:0]  opcode;
  logic [4:0]  pcdata_rs0, pcdata_rs1, pcdata_rd;
  logic [2:0]  pcdata_bc;
  logic        opflag;
  logic        eop;
  logic        busy;
  logic [15:0] issue_cnt;
  logic [7:0]  illegal_cnt;
  logic        timeout_err;

  kore_op_dispatch #(.FIFO_DEPTH(4), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .clr_stat(clr_stat), .opcode(opcode),
    .pcdata_rs0(pcdata_rs0), .pcdata_rs1(pcdata_rs1), .pcdata_rd(pcdata_rd),
    .pcdata_bc(pcdata_bc), .opflag(opflag), .eop(eop), .busy(busy),
    .issue_cnt(issue_cnt), .illegal_cnt(illegal_cnt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_issue = 0;
  int          exp_issue = 0;
  int          exp_illegal = 0;
  logic [24:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [2:0] bc, input logic [4:0] rs0,
                                     input logic [4:0] rs1);
    return {7'h55, rs1, rs0, bc, rd, op};
  endfunction

  function automatic logic [31:0] rnd_legal(input int k);
    logic [6:0] ops [3];
    ops[0] = 7'h01; ops[1] = 7'h02; ops[2] = 7'h04;
    return mk(ops[k % 3], 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom));
  endfunction

  // Every issue pulse must match the oldest legal word still outstanding.
  always @(negedge clk) begin
    if (rst_n && opflag) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        chk("spurious_issue", 32'd1, 32'd0);
      end else begin
        chk("issue_fields", 32'({opcode, pcdata_rd, pcdata_bc, pcdata_rs0, pcdata_rs1}),
            32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push_word(input logic [31:0] w);
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      chk("push_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    in_instr = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (w[6:0] == 7'h01 || w[6:0] == 7'h02 || w[6:0] == 7'h04) begin
      exp_q.push_back({w[6:0], w[11:7], w[14:12], w[19:15], w[24:20]});
      exp_issue++;
    end else if (exp_illegal < 255) begin
      exp_illegal++;
    end
  endtask

  task automatic do_eop();
    @(posedge clk); #1 eop = 1'b1;
    @(posedge clk); #1 eop = 1'b0;
  endtask

  task automatic wait_issue(input int target);
    for (int k = 0; k < 60 && n_issue < target; k++) begin
      @(negedge clk); #1;
    end
    chk("issue_wait", 32'(n_issue >= target), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; clr_stat = 1'b0; eop = 1'b0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_opflag", 32'(opflag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fields", 32'({opcode, pcdata_rd, pcdata_bc, pcdata_rs0, pcdata_rs1}), 32'd0);
    chk("rst_counts", 32'({issue_cnt, illegal_cnt}), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single add: latency and decode.
    @(posedge clk); #1;
    push_word(32'h0020_8102);
    @(negedge clk); chk("lat_cycle1", 32'(opflag), 32'd0);
    @(negedge clk); chk("lat_cycle2", 32'(opflag), 32'd0);
    @(negedge clk); chk("lat_cycle3", 32'(opflag), 32'd1);
    chk("add_opcode", 32'(opcode), 32'h02);
    chk("add_rd", 32'(pcdata_rd), 32'd2);
    chk("add_rs0", 32'(pcdata_rs0), 32'd1);
    chk("add_rs1", 32'(pcdata_rs1), 32'd2);
    chk("add_issue_cnt", 32'(issue_cnt), 32'(exp_issue));
    @(negedge clk); chk("opflag_width", 32'(opflag), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);
    do_eop();
    @(negedge clk); chk("eop_done_busy", 32'(busy), 32'd0);

    // Fill: one issues, four queue, sixth refused.
    base = n_issue;
    for (int i = 0; i < 5; i++) push_word(rnd_legal(i));
    @(negedge clk); chk("full_in_ready", 32'(in_ready), 32'd0);
    #1 in_valid = 1'b1; in_instr = mk(7'h02, 5'd9, 3'd1, 5'd9, 5'd9);
    repeat (3) begin
      @(negedge clk); chk("full_refuse", 32'(in_ready), 32'd0);
    end
    #1 in_valid = 1'b0;
    wait_issue(base + 1);
    for (int i = 0; i < 4; i++) begin
      do_eop();
      wait_issue(base + 2 + i);
    end
    do_eop();
    idle(10);
    chk("fill_issue_total", 32'(n_issue - base), 32'd5);
    chk("fill_issue_cnt", 32'(issue_cnt), 32'(exp_issue));
    chk("fill_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("fill_idle_busy", 32'(busy), 32'd0);

    // Illegal opcode dropped, following add issues.
    base = n_issue;
    push_word(mk(7'h03, 5'd4, 3'd2, 5'd5, 5'd6));
    push_word(mk(7'h02, 5'd7, 3'd3, 5'd8, 5'd9));
    wait_issue(base + 1);
    do_eop();
    idle(5);
    chk("illegal_cnt_one", 32'(illegal_cnt), 32'(exp_illegal));
    chk("illegal_one_issue", 32'(n_issue - base), 32'd1);

    // Back-to-back drops up to saturation.
    foreach (exp_q[i]) ;
    for (int i = 0; i < 260; i++)
      push_word(mk(7'(i % 2 == 0 ? 7'h00 : 7'h7F), 5'(i), 3'd0, 5'd0, 5'd0));
    idle(6);
    chk("illegal_saturate", 32'(illegal_cnt), 32'd255);
    chk("illegal_no_issue", 32'(n_issue - base), 32'd1);

    // clr_stat while idle.
    clr_stat = 1'b1;
    @(posedge clk); #1 clr_stat = 1'b0;
    exp_issue = 0; exp_illegal = 0;
    @(negedge clk);
    chk("clr_counts", 32'({issue_cnt, illegal_cnt}), 32'd0);

    // clr_stat coincident with the ISSUE increment wins.
    base = n_issue;
    push_word(mk(7'h01, 5'd3, 3'd5, 5'd1, 5'd2));
    @(posedge clk); #1 clr_stat = 1'b1;
    @(posedge clk); #1 clr_stat = 1'b0;
    exp_issue = 0;
    @(negedge clk);
    chk("clr_prio_opflag", 32'(opflag), 32'd1);
    chk("clr_prio_issue_cnt", 32'(issue_cnt), 32'(exp_issue));
    do_eop();
    idle(3);

    // eop held high before issue needs a fresh rising edge.
    base = n_issue;
    eop = 1'b1;
    push_word(mk(7'h04, 5'd10, 3'd6, 5'd11, 5'd12));
    wait_issue(base + 1);
    idle(8);
    chk("eop_high_still_wait", 32'(busy), 32'd1);
    eop = 1'b0;
    do_eop();
    @(negedge clk);
    chk("eop_fresh_rise_idle", 32'(busy), 32'd0);

    // Reset mid-WAIT with two queued words.
    base = n_issue;
    push_word(rnd_legal(0));
    push_word(rnd_legal(1));
    push_word(rnd_legal(2));
    wait_issue(base + 1);
    #2 rst_n = 1'b0;
    exp_q.delete(); exp_issue = 0; exp_illegal = 0;
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_counts", 32'({issue_cnt, illegal_cnt}), 32'd0);
    chk("mid_rst_fields", 32'({opcode, pcdata_rd, pcdata_bc, pcdata_rs0, pcdata_rs1}), 32'd0);
    base = n_issue;
    idle(10);
    chk("mid_rst_no_issue", 32'(n_issue - base), 32'd0);
    chk("mid_rst_opflag", 32'(opflag), 32'd0);
    chk("end_timeout_err", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
